// File: rtl/m72_pic.sv
// rtl/m72_pic.sv - 8259A-compatible interrupt controller subset for the M72 main CPU
module m72_pic #(
  parameter int NUM_IRQ = 8
) (
  input  logic        CLK_32M,
  input  logic        reset_n,
  input  logic        CS,
  input  logic        WR,
  input  logic        RD,
  input  logic        A0,
  input  logic [7:0]  DIN,
  output logic [15:0] DOUT,
  output logic        DOUT_VALID,
  input  logic [7:0]  IRQ_IN,
  output logic        INT_REQ,
  input  logic        INT_ACK
);

  localparam logic [8:0] FULL = (9'd1 << NUM_IRQ) - 9'd1;
  localparam logic [7:0] IMPL = FULL[7:0];

  typedef enum logic [2:0] {S_UNINIT, S_ICW2, S_ICW3, S_ICW4, S_READY} state_t;

  state_t      state, state_nx;
  logic [7:0]  irq_q, irr, isr, imr, vec;
  logic [7:0]  irr_nx, isr_nx, pend, vec_now;
  logic [4:0]  base;
  logic        aeoi, rsel, sngl, ic4, wr_q, ack_q, int_req;
  logic        wr_start, ack_start, icw1, a1_wr, ocw1, ocw2, ocw3;
  logic [2:0]  p, isr_lo;
  logic        p_valid, isr_any, qual;

  assign wr_start  = CS & WR & ~wr_q;
  assign ack_start = INT_ACK & ~ack_q;
  assign icw1      = wr_start & ~A0 & DIN[4];
  assign a1_wr     = wr_start & A0;
  assign ocw1      = a1_wr && (state == S_READY);
  assign ocw2      = wr_start && !A0 && (DIN[4:3] == 2'b00) && (state == S_READY);
  assign ocw3      = wr_start && !A0 && (DIN[4:3] == 2'b01) && (state == S_READY);
  assign INT_REQ   = int_req;

  // Fixed priority: lowest-numbered pending level must beat every in-service level.
  always_comb begin
    pend    = irr & ~imr & IMPL;
    p       = 3'd7;
    p_valid = 1'b0;
    isr_lo  = 3'd7;
    isr_any = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (pend[i]) begin
        p       = 3'(i);
        p_valid = 1'b1;
      end
      if (isr[i]) begin
        isr_lo  = 3'(i);
        isr_any = 1'b1;
      end
    end
    qual    = p_valid && (!isr_any || (p < isr_lo)) && (state == S_READY);
    vec_now = {base, qual ? p : 3'd7};
  end

  always_comb begin
    state_nx = state;
    if (icw1) begin
      state_nx = S_ICW2;
    end else if (a1_wr) begin
      case (state)
        S_ICW2:  state_nx = !sngl ? S_ICW3 : (ic4 ? S_ICW4 : S_READY);
        S_ICW3:  state_nx = ic4 ? S_ICW4 : S_READY;
        S_ICW4:  state_nx = S_READY;
        default: state_nx = state;
      endcase
    end
  end

  // A fresh request edge wins over the acknowledge clear on the same level.
  always_comb begin
    irr_nx = irr;
    isr_nx = isr;
    if (ack_start && qual) begin
      irr_nx[p] = 1'b0;
      if (!aeoi) isr_nx[p] = 1'b1;
    end
    irr_nx = (irr_nx | (IRQ_IN & ~irq_q)) & IMPL;
    if (ocw2 && (DIN[7:5] == 3'b001) && isr_any) isr_nx[isr_lo] = 1'b0;
    if (ocw2 && (DIN[7:5] == 3'b011)) isr_nx[DIN[2:0]] = 1'b0;
    if (icw1) isr_nx = 8'h00;
    isr_nx = isr_nx & IMPL;
  end

  always_ff @(posedge CLK_32M) begin
    if (!reset_n) begin
      state   <= S_UNINIT;
      irq_q   <= 8'h00;
      irr     <= 8'h00;
      isr     <= 8'h00;
      imr     <= 8'hFF;
      vec     <= 8'h00;
      base    <= 5'd0;
      aeoi    <= 1'b0;
      rsel    <= 1'b0;
      sngl    <= 1'b0;
      ic4     <= 1'b0;
      wr_q    <= 1'b0;
      ack_q   <= 1'b0;
      int_req <= 1'b0;
    end else begin
      state   <= state_nx;
      irq_q   <= IRQ_IN;
      wr_q    <= CS & WR;
      ack_q   <= INT_ACK;
      int_req <= qual;
      irr     <= irr_nx;
      isr     <= isr_nx;
      if (icw1) begin
        imr  <= 8'h00;
        rsel <= 1'b0;
        sngl <= DIN[1];
        ic4  <= DIN[0];
      end
      if (a1_wr && (state == S_ICW2)) base <= DIN[7:3];
      if (a1_wr && (state == S_ICW4)) aeoi <= DIN[1];
      if (ocw1) imr <= DIN;
      if (ocw3 && DIN[1]) rsel <= DIN[0];
      if (ack_start) vec <= vec_now;
    end
  end

  // The vector is live from the first ack cycle, then held stable until INT_ACK falls.
  always_comb begin
    DOUT       = 16'h0000;
    DOUT_VALID = 1'b0;
    if (INT_ACK) begin
      DOUT_VALID = 1'b1;
      DOUT       = {8'h00, ack_q ? vec : vec_now};
    end else if (CS && RD) begin
      DOUT_VALID = 1'b1;
      DOUT       = {8'h00, A0 ? (imr & IMPL) : (rsel ? isr : irr)};
    end
  end

endmodule

// File: tb/tb_m72_pic.sv
// tb/tb_m72_pic.sv - self-checking bench for m72_pic with a behavioural controller model
module tb_m72_pic;

  logic        clk_32m = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0, wr_s = 1'b0, rd_s = 1'b0, a0 = 1'b0, int_ack = 1'b0;
  logic [7:0]  din = 8'h00, irq_in = 8'h00;
  logic [15:0] dout;
  logic        dout_valid, int_req;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] got, exp;
  logic        vld;

  // Model state: m_st 0=UNINIT 1=ICW2 2=ICW3 3=ICW4 4=READY
  logic [7:0] m_irr, m_isr, m_imr;
  logic [4:0] m_base;
  bit         m_aeoi, m_rsel, m_sngl, m_ic4;
  int         m_st;

  m72_pic #(.NUM_IRQ(8)) dut (
    .CLK_32M(clk_32m), .reset_n(reset_n), .CS(cs), .WR(wr_s), .RD(rd_s), .A0(a0),
    .DIN(din), .DOUT(dout), .DOUT_VALID(dout_valid), .IRQ_IN(irq_in),
    .INT_REQ(int_req), .INT_ACK(int_ack)
  );

  always #5 clk_32m = ~clk_32m;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic void m_reset();
    m_st = 0; m_irr = 8'h00; m_isr = 8'h00; m_imr = 8'hFF;
    m_base = 5'd0; m_aeoi = 0; m_rsel = 0; m_sngl = 0; m_ic4 = 0;
  endfunction

  // Highest-priority level the CPU should be interrupted for, or -1.
  function automatic int m_qual();
    int p = -1;
    if (m_st != 4) return -1;
    for (int i = 0; i < 8; i++) if (m_irr[i] && !m_imr[i]) begin p = i; break; end
    if (p < 0) return -1;
    for (int j = 0; j <= p; j++) if (m_isr[j]) return -1;
    return p;
  endfunction

  function automatic logic m_req();
    return m_qual() >= 0;
  endfunction

  function automatic logic [15:0] m_rd(input bit sel);
    return {8'h00, sel ? m_imr : (m_rsel ? m_isr : m_irr)};
  endfunction

  function automatic void m_write(input bit sel, input logic [7:0] d);
    if (!sel && d[4]) begin
      m_isr = 8'h00; m_imr = 8'h00; m_rsel = 0; m_sngl = d[1]; m_ic4 = d[0]; m_st = 1;
    end else begin
      case (m_st)
        1: if (sel) begin m_base = d[7:3]; m_st = !m_sngl ? 2 : (m_ic4 ? 3 : 4); end
        2: if (sel) m_st = m_ic4 ? 3 : 4;
        3: if (sel) begin m_aeoi = d[1]; m_st = 4; end
        4: begin
          if (sel) m_imr = d;
          else if (d[4:3] == 2'b00) begin
            if (d[7:5] == 3'd1) begin
              for (int j = 0; j < 8; j++) if (m_isr[j]) begin m_isr[j] = 1'b0; break; end
            end else if (d[7:5] == 3'd3) m_isr[d[2:0]] = 1'b0;
          end else if (d[4:3] == 2'b01 && d[1]) m_rsel = d[0];
        end
        default: ;
      endcase
    end
  endfunction

  task automatic tick();
    @(posedge clk_32m);
    #1;
  endtask

  task automatic wr(input bit sel, input logic [7:0] d, input int n = 1);
    cs = 1; wr_s = 1; a0 = sel; din = d;
    repeat (n) tick();
    cs = 0; wr_s = 0;
    tick();
    m_write(sel, d);
  endtask

  task automatic irq(input logic [7:0] m);
    irq_in = m; tick(); irq_in = 8'h00; tick();
    m_irr = m_irr | m;
  endtask

  task automatic ack(output logic [15:0] g, output logic [15:0] e, output logic v);
    int q;
    q = m_qual();
    int_ack = 1; tick(); tick();
    g = dout; v = dout_valid;
    int_ack = 0; tick();
    if (q >= 0) begin
      e = {8'h00, m_base, 3'(q)};
      m_irr[q] = 1'b0;
      if (!m_aeoi) m_isr[q] = 1'b1;
    end else e = {8'h00, m_base, 3'd7};
  endtask

  task automatic rd(input bit sel, output logic [15:0] g, output logic v);
    cs = 1; rd_s = 1; a0 = sel;
    #1;
    g = dout; v = dout_valid;
    cs = 0; rd_s = 0;
    tick();
  endtask

  task automatic init_std();
    wr(0, 8'h17); wr(1, 8'h20); wr(1, 8'h01); wr(1, 8'hFA);
  endtask

  task automatic test_reset();
    reset_n = 0; repeat (3) tick(); reset_n = 1; tick(); m_reset();
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL reset_int_req got=%b exp=0", int_req); end
    tests_run++; if (dout !== 16'h0000) begin tests_failed++; $display("FAIL reset_dout got=%h exp=0000", dout); end
    tests_run++; if (dout_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
    rd(1, got, vld);
    tests_run++; if (got !== 16'h00FF || vld !== 1'b1) begin tests_failed++; $display("FAIL reset_imr got=%h/%b exp=00ff/1", got, vld); end
    rd(0, got, vld);
    tests_run++; if (got !== 16'h0000) begin tests_failed++; $display("FAIL reset_irr got=%h exp=0000", got); end
  endtask

  task automatic test_init_vblank();
    init_std();
    irq_in = 8'h01; tick();
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL vblank_early_req got=%b exp=0", int_req); end
    irq_in = 8'h00; tick(); m_irr[0] = 1'b1;
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL vblank_req got=%b exp=1", int_req); end
    ack(got, exp, vld);
    tests_run++; if (got !== 16'h0020 || got !== exp || vld !== 1'b1) begin tests_failed++; $display("FAIL vblank_vec got=%h/%b exp=0020/1", got, vld); end
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL vblank_req_drop got=%b exp=0", int_req); end
    wr(0, 8'h0B); rd(0, got, vld);
    tests_run++; if (got !== 16'h0001) begin tests_failed++; $display("FAIL vblank_isr got=%h exp=0001", got); end
    wr(0, 8'h20); rd(0, got, vld);
    tests_run++; if (got !== 16'h0000) begin tests_failed++; $display("FAIL vblank_eoi_isr got=%h exp=0000", got); end
  endtask

  task automatic test_priority();
    init_std();
    irq(8'h05);
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL prio_req got=%b exp=1", int_req); end
    ack(got, exp, vld);
    tests_run++; if (got !== 16'h0020) begin tests_failed++; $display("FAIL prio_vec0 got=%h exp=0020", got); end
    repeat (3) tick();
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL prio_blocked got=%b exp=0", int_req); end
    wr(0, 8'h20);
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL prio_after_eoi got=%b exp=1", int_req); end
    ack(got, exp, vld);
    tests_run++; if (got !== 16'h0022) begin tests_failed++; $display("FAIL prio_vec2 got=%h exp=0022", got); end
    wr(0, 8'h20);
  endtask

  task automatic test_nesting();
    irq(8'h04); ack(got, exp, vld);
    irq(8'h01);
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL nest_preempt got=%b exp=1", int_req); end
    ack(got, exp, vld);
    tests_run++; if (got !== 16'h0020) begin tests_failed++; $display("FAIL nest_vec got=%h exp=0020", got); end
    wr(0, 8'h62);
    irq(8'h04);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL nest_lower_blocked got=%b exp=0", int_req); end
    wr(0, 8'h60); wr(0, 8'h0B); rd(0, got, vld);
    tests_run++; if (got !== 16'h0000) begin tests_failed++; $display("FAIL nest_specific_eoi got=%h exp=0000", got); end
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL nest_req_lvl2 got=%b exp=1", int_req); end
    ack(got, exp, vld);
    tests_run++; if (got !== 16'h0022) begin tests_failed++; $display("FAIL nest_vec2 got=%h exp=0022", got); end
    wr(0, 8'h20);
  endtask

  task automatic test_mask_readback();
    wr(1, 8'hFF); irq(8'h01);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL mask_req got=%b exp=0", int_req); end
    wr(0, 8'h0A); rd(0, got, vld);
    tests_run++; if (got !== 16'h0001) begin tests_failed++; $display("FAIL mask_irr got=%h exp=0001", got); end
    rd(1, got, vld);
    tests_run++; if (got !== 16'h00FF) begin tests_failed++; $display("FAIL mask_imr got=%h exp=00ff", got); end
    wr(1, 8'hFE);
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL unmask_req got=%b exp=1", int_req); end
    ack(got, exp, vld); wr(0, 8'h0B); rd(0, got, vld);
    tests_run++; if (got !== 16'h0001) begin tests_failed++; $display("FAIL ocw3_isr got=%h exp=0001", got); end
    wr(0, 8'h20);
    wr(1, 8'h00); irq(8'h04); ack(got, exp, vld); irq(8'h01); ack(got, exp, vld);
    wr(0, 8'h20, 3); rd(0, got, vld);
    tests_run++; if (got !== 16'h0004 || got !== m_rd(0)) begin tests_failed++; $display("FAIL multicycle_write got=%h exp=0004", got); end
    wr(0, 8'h20);
  endtask

  task automatic test_spurious_aeoi();
    irq(8'h04); ack(got, exp, vld);
    wr(1, 8'hFF); ack(got, exp, vld);
    tests_run++; if (got !== 16'h0027 || got !== exp) begin tests_failed++; $display("FAIL spurious_vec got=%h exp=0027", got); end
    rd(0, got, vld);
    tests_run++; if (got !== 16'h0004) begin tests_failed++; $display("FAIL spurious_isr got=%h exp=0004", got); end
    wr(0, 8'h20);
    wr(0, 8'h17); wr(1, 8'h20); wr(1, 8'h03); wr(1, 8'hFA);
    irq(8'h01); ack(got, exp, vld);
    tests_run++; if (got !== 16'h0020) begin tests_failed++; $display("FAIL aeoi_vec got=%h exp=0020", got); end
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL aeoi_req got=%b exp=0", int_req); end
    wr(0, 8'h0B); rd(0, got, vld);
    tests_run++; if (got !== 16'h0000) begin tests_failed++; $display("FAIL aeoi_isr got=%h exp=0000", got); end
  endtask

  task automatic test_reset_reinit();
    wr(0, 8'h17); wr(1, 8'h20);
    reset_n = 0; tick(); reset_n = 1; tick(); m_reset();
    wr(1, 8'h01); irq(8'h01); repeat (2) tick();
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL reinit_uninit_req got=%b exp=0", int_req); end
    rd(1, got, vld);
    tests_run++; if (got !== 16'h00FF) begin tests_failed++; $display("FAIL reinit_imr got=%h exp=00ff", got); end
    wr(0, 8'h17); wr(1, 8'h20);
    tests_run++; if (int_req !== 1'b0) begin tests_failed++; $display("FAIL reinit_partial_req got=%b exp=0", int_req); end
    wr(1, 8'h01);
    tests_run++; if (int_req !== 1'b1) begin tests_failed++; $display("FAIL reinit_ready_req got=%b exp=1", int_req); end
    ack(got, exp, vld);
    wr(0, 8'h17); rd(1, got, vld);
    tests_run++; if (got !== 16'h0000) begin tests_failed++; $display("FAIL icw1_imr got=%h exp=0000", got); end
    wr(1, 8'h20); wr(1, 8'h01); wr(0, 8'h0B); rd(0, got, vld);
    tests_run++; if (got !== 16'h0000) begin tests_failed++; $display("FAIL icw1_isr got=%h exp=0000", got); end
  endtask

  task automatic test_random();
    logic [7:0] d;
    int op;
    bit sel;
    d = 8'($urandom);
    wr(0, 8'h17); wr(1, {d[4:0], 3'b000}); wr(1, {6'b0, d[7], 1'b1}); wr(1, 8'($urandom));
    for (int it = 0; it < 200; it++) begin
      op = $urandom_range(0, 6);
      case (op)
        0: irq(8'(1 << $urandom_range(0, 7)));
        1: irq(8'($urandom) & 8'($urandom));
        2: begin
          ack(got, exp, vld);
          tests_run++; if (got !== exp || vld !== 1'b1) begin tests_failed++; $display("FAIL rand_ack it=%0d got=%h exp=%h", it, got, exp); end
        end
        3: wr(1, 8'($urandom) & 8'($urandom));
        4: wr(0, ($urandom_range(0, 1) != 0) ? 8'h20 : {5'b01100, 3'($urandom_range(0, 7))});
        5: wr(0, {7'b0000101, 1'($urandom_range(0, 1))});
        default: begin
          sel = 1'($urandom_range(0, 1));
          rd(sel, got, vld);
          tests_run++; if (got !== m_rd(sel)) begin tests_failed++; $display("FAIL rand_read it=%0d a0=%0d got=%h exp=%h", it, sel, got, m_rd(sel)); end
        end
      endcase
      tests_run++; if (int_req !== m_req()) begin tests_failed++; $display("FAIL rand_int_req it=%0d got=%b exp=%b", it, int_req, m_req()); end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_init_vblank();
    test_priority();
    test_nesting();
    test_mask_readback();
    test_spurious_aeoi();
    test_reset_reinit();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
